arith_order_sched: RTL and testbench
====================================

Name: arith_order_sched

Overview:
- Scheduler in front of the local program sequencer (arithmetic control).
- Serialises arithmetic orders from the operation unit (op) and shift orders from the io unit onto that sequencer, allowing one order in flight at a time.
- Routes the sequencer's answer back to the requester that issued the order.
- Detects orders that never answer (add/div overflow, hang) with a watchdog. On watchdog expiry it pulses a clear that forces the sequencer's state machines idle, and reports a fault.

Parameters:
- TIMEOUT, 80, max WAIT cycles before fault (sized above worst-case div of about 64 cycles); legal range 2..127.
- CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- op_req  in  1  level; op requests an order; held until op_grant or op_fault
- op_code  in  3  0 add, 1 sub, 2 mul, 3 div, 4 and, 5-7 illegal; stable while op_req=1
- io_req  in  1  level; io requests a shift order; held until io_grant
- io_shift_4  in  1  1 = 4-bit shift, 0 = 3-bit shift; stable while io_req=1
- abort_from_pu  in  1  pulse; same as the clear-A pulse from pu
- ac_answer_op  in  1  pulse, answer to op from sequencer
- ac_answer_io  in  1  pulse, answer to io from sequencer
- order_add_to_ac, order_sub_to_ac, order_mul_to_ac, order_div_to_ac, order_and_to_ac, order_io_to_ac  out  1 each  pulse
- shift_3_bit_to_ac, shift_4_bit_to_ac  out  1 each  level
- clear_ac  out  1  pulse; ORed into sequencer clear-A outside this block
- op_grant, op_done, op_fault  out  1 each  pulse
- io_grant, io_done, io_fault  out  1 each  pulse
- busy  out  1  level; state != IDLE
- fault_cause  out  2  sticky; 0 none, 1 timeout, 2 illegal code; updated on each fault

Behaviour:
- All outputs are Moore-decoded from registered state plus latched owner/code. No combinational input-to-output path.
- Reset (resetn=0 at a clk edge):
  - state IDLE, counter 0, owner op, last_io 0, fault_cause 0.
  - All pulse outputs 0, shift levels 0, busy 0.
- States: IDLE, ISSUE, WAIT, RESP, FAULT.
- IDLE: evaluate requests.
  - Only one request pending: select it.
  - Both pending: select io if last_io=0, else op (alternating fairness). last_io updates on every grant.
  - Selected op with code 5-7: go to FAULT with cause 2.
  - Otherwise latch owner, code and shift_4, then go to ISSUE.
- ISSUE (1 cycle):
  - Pulse the requester's grant.
  - Pulse exactly one order_*_to_ac matching the latched code (io owner gives order_io_to_ac).
  - Clear the counter; go to WAIT.
- WAIT:
  - Answer from owner's line (ac_answer_op if owner op, ac_answer_io if owner io): go to RESP.
  - Answer on the other line: ignored.
  - No answer and counter==TIMEOUT-1: go to FAULT with cause 1.
  - Otherwise counter+1.
- RESP (1 cycle): pulse owner's done; go to IDLE.
- FAULT (1 cycle):
  - Pulse owner's fault and load fault_cause.
  - Cause 1: also pulse clear_ac.
  - Cause 2: also pulse op_grant, so op drops op_req; no order is issued and clear_ac is not pulsed.
  - Go to IDLE.
- Shift levels: while owner io and state in {ISSUE, WAIT, RESP}:
  - shift_4_bit_to_ac = shift_4.
  - shift_3_bit_to_ac = !shift_4.
  - Both are 0 otherwise.
- Latency:
  - Request sampled in IDLE at cycle T: grant and order at T+1.
  - Answer at cycle W: done at W+1.
  - Idle-to-idle turnaround is 4 + (W - first WAIT cycle) cycles.
  - A request still high in IDLE after done is treated as a new request.
- abort_from_pu has highest priority in every state:
  - Next state IDLE, counter 0.
  - No done, fault or clear_ac pulse; fault_cause and last_io unchanged.
  - If abort coincides with an answer in WAIT, the answer is dropped.
- Simultaneous op_req and io_req with a TIMEOUT fault: the fault is served first, then fairness applies in IDLE.
- Requests arriving while busy are not lost; they wait because the requester holds req.
- busy=1 in every non-IDLE state, including FAULT.

Test Plan:
- op_req, code 0 (add); ac_answer_op pulsed 2 cycles after order_add_to_ac -> op_grant and order_add_to_ac in the same cycle; op_done 1 cycle after the answer; busy high exactly 4 cycles; fault_cause stays 0.
- op_req and io_req asserted together from reset, io_shift_4=1; each answered after 5 cycles -> io served first (order_io_to_ac with shift_4_bit_to_ac=1 held through RESP), then op; on the next simultaneous pair, op is served first.
- op_req, code 3 (div) with no answer, TIMEOUT=80 -> after 80 WAIT cycles: one cycle with op_fault=1, clear_ac=1, fault_cause=1; then IDLE.
- op_req, code 6 -> no order pulse; op_grant and op_fault in the same cycle; fault_cause=2; clear_ac=0.
- io_req, shift_4=0; ac_answer_op pulsed in WAIT, then ac_answer_io 3 cycles later -> the stray answer is ignored; io_done follows only the io answer; shift_3_bit_to_ac=1 throughout.
- mul in WAIT at counter 10, abort_from_pu pulsed together with ac_answer_op -> IDLE next cycle; no op_done, op_fault or clear_ac; a new op_req is granted 2 cycles after abort.

Source files
------------

// File: rtl/arith_order_sched_if.sv
// -----------------------------------------------------------------------------
// arith_order_sched_if
//
// Handshake bundle between the arithmetic order scheduler, its two requesters
// (operation unit "op" and io unit "io") and the local program sequencer.
//
//   Requester side : op_req/op_code, io_req/io_shift_4, abort_from_pu
//                    op_grant/op_done/op_fault, io_grant/io_done/io_fault
//   Sequencer side : order_*_to_ac pulses, shift_3/4_bit_to_ac levels,
//                    clear_ac pulse, ac_answer_op/ac_answer_io pulses
//   Status         : busy, fault_cause
//
// Modports:
//   slave  - the scheduler itself
//   master - the environment (requesters + sequencer) driving the scheduler
// -----------------------------------------------------------------------------
interface arith_order_sched_if;
  // requests from the op and io units
  logic       op_req;
  logic [2:0] op_code;
  logic       io_req;
  logic       io_shift_4;
  logic       abort_from_pu;

  // answers from the sequencer
  logic       ac_answer_op;
  logic       ac_answer_io;

  // orders to the sequencer
  logic       order_add_to_ac;
  logic       order_sub_to_ac;
  logic       order_mul_to_ac;
  logic       order_div_to_ac;
  logic       order_and_to_ac;
  logic       order_io_to_ac;
  logic       shift_3_bit_to_ac;
  logic       shift_4_bit_to_ac;
  logic       clear_ac;

  // handshake back to the requesters
  logic       op_grant;
  logic       op_done;
  logic       op_fault;
  logic       io_grant;
  logic       io_done;
  logic       io_fault;

  // status
  logic       busy;
  logic [1:0] fault_cause;

  modport slave (
    input  op_req, op_code, io_req, io_shift_4, abort_from_pu,
    input  ac_answer_op, ac_answer_io,
    output order_add_to_ac, order_sub_to_ac, order_mul_to_ac,
    output order_div_to_ac, order_and_to_ac, order_io_to_ac,
    output shift_3_bit_to_ac, shift_4_bit_to_ac, clear_ac,
    output op_grant, op_done, op_fault,
    output io_grant, io_done, io_fault,
    output busy, fault_cause
  );

  modport master (
    output op_req, op_code, io_req, io_shift_4, abort_from_pu,
    output ac_answer_op, ac_answer_io,
    input  order_add_to_ac, order_sub_to_ac, order_mul_to_ac,
    input  order_div_to_ac, order_and_to_ac, order_io_to_ac,
    input  shift_3_bit_to_ac, shift_4_bit_to_ac, clear_ac,
    input  op_grant, op_done, op_fault,
    input  io_grant, io_done, io_fault,
    input  busy, fault_cause
  );
endinterface

// File: rtl/arith_order_sched.sv
// -----------------------------------------------------------------------------
// arith_order_sched
//
// Scheduler in front of the local program sequencer. Serialises arithmetic
// orders from the op unit and shift orders from the io unit so that exactly
// one order is in flight, routes the sequencer's answer back to the requester
// that owns the order, and runs a watchdog that clears the sequencer and
// reports a fault when an order never answers.
//
// Ports:
//   clk    - clock
//   resetn - synchronous, active-low reset
//   bus    - arith_order_sched_if.slave (requests, orders, answers, status)
//
// Parameters:
//   TIMEOUT - WAIT cycles allowed before a watchdog fault (2..127)
//   CNT_W   - watchdog counter width, 2**CNT_W must exceed TIMEOUT
//
// All outputs are decoded from registered state plus the latched owner/code;
// no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module arith_order_sched #(
  parameter int TIMEOUT = 80,
  parameter int CNT_W   = 7
) (
  input logic               clk,
  input logic               resetn,
  arith_order_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;

  localparam logic [2:0] CODE_ADD = 3'd0;
  localparam logic [2:0] CODE_SUB = 3'd1;
  localparam logic [2:0] CODE_MUL = 3'd2;
  localparam logic [2:0] CODE_DIV = 3'd3;
  localparam logic [2:0] CODE_AND = 3'd4;

  // control state (reset)
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             owner_io, owner_io_nxt;   // 1: io owns the order, 0: op
  logic             last_io, last_io_nxt;     // fairness: last grant went to io
  logic [1:0]       cause_q, cause_nxt;

  // latched order payload (not reset; only meaningful while owned)
  logic [2:0]       code_q, code_nxt;
  logic             shift4_q, shift4_nxt;

  logic             sel_io;
  logic             owner_answer;
  logic             illegal_code;

  // With both requests pending, io wins only if op got the previous grant.
  assign sel_io       = bus.io_req && (!bus.op_req || !last_io);
  assign owner_answer = owner_io ? bus.ac_answer_io : bus.ac_answer_op;
  assign illegal_code = (bus.op_code > CODE_AND);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      owner_io <= 1'b0;
      last_io  <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      owner_io <= owner_io_nxt;
      last_io  <= last_io_nxt;
      cause_q  <= cause_nxt;
    end
  end

  always_ff @(posedge clk) begin
    code_q   <= code_nxt;
    shift4_q <= shift4_nxt;
  end

  // Next-state logic. Abort from pu overrides every state and leaves the
  // sticky fault cause and the fairness bit untouched.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    owner_io_nxt = owner_io;
    last_io_nxt  = last_io;
    cause_nxt    = cause_q;
    code_nxt     = code_q;
    shift4_nxt   = shift4_q;

    if (bus.abort_from_pu) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.io_req || bus.op_req) begin
            owner_io_nxt = sel_io;
            last_io_nxt  = sel_io;
            if (sel_io) begin
              shift4_nxt = bus.io_shift_4;
              state_nxt  = S_ISSUE;
            end else begin
              code_nxt = bus.op_code;
              // An illegal op code never reaches the sequencer; the FAULT
              // cycle grants it so the op unit drops its request.
              if (illegal_code) begin
                cause_nxt = CAUSE_ILLEGAL;
                state_nxt = S_FAULT;
              end else begin
                state_nxt = S_ISSUE;
              end
            end
          end
        end

        S_ISSUE: begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT;
        end

        S_WAIT: begin
          // Answers on the non-owner line are strays and are ignored.
          if (owner_answer) begin
            state_nxt = S_RESP;
          end else if (cnt == CNT_LAST) begin
            cause_nxt = CAUSE_TIMEOUT;
            state_nxt = S_FAULT;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end

        S_RESP:  state_nxt = S_IDLE;
        S_FAULT: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Moore output decode from state, owner and latched code.
  always_comb begin
    bus.order_add_to_ac   = 1'b0;
    bus.order_sub_to_ac   = 1'b0;
    bus.order_mul_to_ac   = 1'b0;
    bus.order_div_to_ac   = 1'b0;
    bus.order_and_to_ac   = 1'b0;
    bus.order_io_to_ac    = 1'b0;
    bus.shift_3_bit_to_ac = 1'b0;
    bus.shift_4_bit_to_ac = 1'b0;
    bus.clear_ac          = 1'b0;
    bus.op_grant          = 1'b0;
    bus.op_done           = 1'b0;
    bus.op_fault          = 1'b0;
    bus.io_grant          = 1'b0;
    bus.io_done           = 1'b0;
    bus.io_fault          = 1'b0;
    bus.busy              = (state != S_IDLE);
    bus.fault_cause       = cause_q;

    case (state)
      S_ISSUE: begin
        if (owner_io) begin
          bus.io_grant       = 1'b1;
          bus.order_io_to_ac = 1'b1;
        end else begin
          bus.op_grant = 1'b1;
          case (code_q)
            CODE_ADD: bus.order_add_to_ac = 1'b1;
            CODE_SUB: bus.order_sub_to_ac = 1'b1;
            CODE_MUL: bus.order_mul_to_ac = 1'b1;
            CODE_DIV: bus.order_div_to_ac = 1'b1;
            CODE_AND: bus.order_and_to_ac = 1'b1;
            default:  ;
          endcase
        end
      end

      S_RESP: begin
        bus.io_done = owner_io;
        bus.op_done = !owner_io;
      end

      S_FAULT: begin
        bus.io_fault = owner_io;
        bus.op_fault = !owner_io;
        // cause_q was loaded on entry to FAULT, so it names this fault.
        bus.clear_ac = (cause_q == CAUSE_TIMEOUT);
        bus.op_grant = (cause_q == CAUSE_ILLEGAL) && !owner_io;
      end

      default: ;
    endcase

    // The shift width is presented for the whole life of an io order.
    if (owner_io && (state == S_ISSUE || state == S_WAIT || state == S_RESP)) begin
      bus.shift_4_bit_to_ac = shift4_q;
      bus.shift_3_bit_to_ac = !shift4_q;
    end
  end

endmodule

// File: tb/tb_arith_order_sched.sv
// -----------------------------------------------------------------------------
// tb_arith_order_sched
//
// Directed plus randomized bench for arith_order_sched. A transaction-level
// reference (pending requests, fairness bit, sticky cause) predicts, for each
// cycle of an order's life, the full output vector of the scheduler.
// -----------------------------------------------------------------------------
module tb_arith_order_sched;
  localparam int TIMEOUT = 80;
  localparam int CNT_W   = 7;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  arith_order_sched_if bus();

  arith_order_sched #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int busy_seen = 0;

  // reference state
  bit         m_last_io = 1'b0;
  logic [1:0] m_cause   = 2'd0;
  bit         op_pend   = 1'b0;
  bit         io_pend   = 1'b0;
  logic [2:0] op_code_v = 3'd0;
  bit         io_s4_v   = 1'b0;

  // {op_grant, io_grant, add, sub, mul, div, and, io, op_done, io_done,
  //  op_fault, io_fault, clear_ac, busy, shift3, shift4, fault_cause[1:0]}
  function automatic logic [17:0] observe();
    return {bus.op_grant, bus.io_grant,
            bus.order_add_to_ac, bus.order_sub_to_ac, bus.order_mul_to_ac,
            bus.order_div_to_ac, bus.order_and_to_ac, bus.order_io_to_ac,
            bus.op_done, bus.io_done, bus.op_fault, bus.io_fault,
            bus.clear_ac, bus.busy, bus.shift_3_bit_to_ac, bus.shift_4_bit_to_ac,
            bus.fault_cause};
  endfunction

  function automatic logic [17:0] exp_vec(input bit own_io, input bit grant,
                                          input bit order, input bit done,
                                          input bit fault, input bit clr,
                                          input bit busy, input bit shift_on,
                                          input bit s4, input logic [2:0] code,
                                          input logic [1:0] cause);
    logic [5:0] ord;
    ord = 6'b000000;
    if (order) ord = own_io ? 6'b000001 : (6'b100000 >> code);
    return {grant && !own_io, grant && own_io, ord,
            done && !own_io, done && own_io, fault && !own_io, fault && own_io,
            clr, busy, shift_on && own_io && !s4, shift_on && own_io && s4, cause};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [17:0] exp);
    logic [17:0] obs;
    obs = observe();
    if (obs[4]) busy_seen++;
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic req_op(input logic [2:0] code);
    bus.op_req  = 1'b1;
    bus.op_code = code;
    op_pend     = 1'b1;
    op_code_v   = code;
  endtask

  task automatic req_io(input bit s4);
    bus.io_req     = 1'b1;
    bus.io_shift_4 = s4;
    io_pend        = 1'b1;
    io_s4_v        = s4;
  endtask

  task automatic drive_answer(input bit to_io, input bit v);
    if (to_io) bus.ac_answer_io = v;
    else       bus.ac_answer_op = v;
  endtask

  task automatic idle_check(input string tag);
    check(tag, exp_vec(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 3'd0, m_cause));
  endtask

  // Serve one order from the currently pending requests, starting in IDLE.
  // delay    : WAIT cycles before the answer cycle (<0: never answer)
  // stray_at : WAIT index at which the non-owner answer line pulses (<0: none)
  task automatic serve_one(input int delay, input int stray_at);
    bit w;
    w = io_pend && (!op_pend || !m_last_io);
    m_last_io = w;
    tick();
    if (!w && op_code_v >= 3'd5) begin
      m_cause = 2'd2;
      check("illegal_fault", exp_vec(1'b0, 1, 0, 0, 1, 0, 1, 0, 1'b0, op_code_v, m_cause));
      bus.op_req = 1'b0;
      op_pend = 1'b0;
      tick();
      idle_check("illegal_idle");
      return;
    end
    check(w ? "io_issue" : "op_issue",
          exp_vec(w, 1, 1, 0, 0, 0, 1, 1, io_s4_v, op_code_v, m_cause));
    if (w) begin bus.io_req = 1'b0; io_pend = 1'b0; end
    else   begin bus.op_req = 1'b0; op_pend = 1'b0; end
    tick();
    if (delay < 0) begin
      for (int i = 0; i < TIMEOUT; i++) begin
        check("timeout_wait", exp_vec(w, 0, 0, 0, 0, 0, 1, 1, io_s4_v, op_code_v, m_cause));
        tick();
      end
      m_cause = 2'd1;
      check("timeout_fault", exp_vec(w, 0, 0, 0, 1, 1, 1, 0, io_s4_v, op_code_v, m_cause));
      tick();
      idle_check("timeout_idle");
      return;
    end
    for (int i = 0; i < delay; i++) begin
      check("wait", exp_vec(w, 0, 0, 0, 0, 0, 1, 1, io_s4_v, op_code_v, m_cause));
      drive_answer(!w, i == stray_at);
      tick();
    end
    drive_answer(!w, 1'b0);
    check("answer_cycle", exp_vec(w, 0, 0, 0, 0, 0, 1, 1, io_s4_v, op_code_v, m_cause));
    drive_answer(w, 1'b1);
    tick();
    drive_answer(w, 1'b0);
    check(w ? "io_done" : "op_done", exp_vec(w, 0, 0, 1, 0, 0, 1, 1, io_s4_v, op_code_v, m_cause));
    tick();
    idle_check("resp_idle");
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    m_last_io = 1'b0;
    m_cause   = 2'd0;
    idle_check("reset_state");
    resetn = 1'b1;
    tick();
    idle_check("idle_after_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int npairs;
    int delay;
    int stray;
    int c;
    bus.op_req        = 1'b0;
    bus.op_code       = 3'd0;
    bus.io_req        = 1'b0;
    bus.io_shift_4    = 1'b0;
    bus.abort_from_pu = 1'b0;
    bus.ac_answer_op  = 1'b0;
    bus.ac_answer_io  = 1'b0;

    do_reset();

    // simultaneous pair from reset: io first, then op against a re-raised io
    req_io(1'b1);
    req_op(3'd1);
    serve_one(4, -1);
    req_io(1'b1);
    serve_one(4, -1);
    serve_one(4, -1);

    // add answered 2 cycles after the order: busy exactly 4 cycles
    busy_seen = 0;
    req_op(3'd0);
    serve_one(1, -1);
    check_int("add_busy_cycles", busy_seen, 4);

    // div with no answer: watchdog fault with clear_ac
    req_op(3'd3);
    serve_one(-1, -1);

    // illegal code
    req_op(3'd6);
    serve_one(0, -1);

    // io 3-bit shift with a stray op answer
    req_io(1'b0);
    serve_one(3, 0);

    // mul aborted at watchdog count 10 together with an answer
    req_op(3'd2);
    m_last_io = 1'b0;
    tick();
    check("abort_issue", exp_vec(1'b0, 1, 1, 0, 0, 0, 1, 1, 1'b0, 3'd2, m_cause));
    bus.op_req = 1'b0;
    op_pend = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("abort_wait", exp_vec(1'b0, 0, 0, 0, 0, 0, 1, 1, 1'b0, 3'd2, m_cause));
      tick();
    end
    bus.abort_from_pu = 1'b1;
    bus.ac_answer_op  = 1'b1;
    tick();
    bus.abort_from_pu = 1'b0;
    bus.ac_answer_op  = 1'b0;
    idle_check("abort_idle");
    req_op(3'd4);
    serve_one(2, -1);

    // randomized traffic
    npairs = 25;
    for (int n = 0; n < npairs; n++) begin
      c = $urandom_range(1, 3);
      if (c[0]) begin
        int k;
        k = $urandom_range(0, 11);
        req_op(k < 8 ? 3'(k) : 3'(k - 8));
      end
      if (c[1]) req_io(1'($urandom_range(0, 1)));
      while (op_pend || io_pend) begin
        delay = $urandom_range(0, 12);
        if ($urandom_range(0, 15) == 0) delay = -1;
        stray = -1;
        if (delay > 0 && $urandom_range(0, 1) == 1) stray = $urandom_range(0, delay - 1);
        serve_one(delay, stray);
      end
    end

    // reset clears the sticky cause and fairness: io wins the next pair
    do_reset();
    req_op(3'd0);
    req_io(1'b0);
    serve_one(0, -1);
    serve_one(0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
